// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

  localparam int          ADDR_W_DEF   = 8;
  localparam int          DATA_W_DEF   = 32;
  localparam logic [7:0]  RESET_PC_DEF = 8'h00;
  // Byte distance between sequential instructions.
  localparam int          PC_STEP      = 4;

  // IDLE: one settling cycle after reset.
  // REQ: a memory read is outstanding.
  // HOLD: a fetched word is waiting for decode.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Address-width register with async active-low reset and a load enable.
// Holds the program counter and the pending redirect target.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  // Load a new value when enabled, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one memory read at a
// time, hands fetched words to decode and redirects on taken branches.
//
// Handshakes: a transfer happens on a rising edge where the producer's
// valid (mem_req / instr_valid) and the consumer's acknowledge
// (mem_ack / instr_ready) are both high. Once raised, mem_req and
// mem_addr stay stable until mem_ack; instr_valid, instr and instr_pc stay
// stable until instr_ready or a branch drops the instruction.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output fetch_state_e      dbg_state
);

  fetch_state_e      state_q, state_d;
  logic              squash_q, squash_d;
  logic [ADDR_W-1:0] pc_q, pc_d, redir_q;
  logic              pc_ld, redir_ld, capture;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;

  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_ld),
    .d     (pc_d),
    .q     (pc_q)
  );

  // The redirect register only ever latches the newest branch target.
  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_redir (
    .clk   (clk),
    .reset (reset),
    .load  (redir_ld),
    .d     (branch_target),
    .q     (redir_q)
  );

  // Next-state, PC update and capture decisions.
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    pc_ld    = 1'b0;
    pc_d     = pc_q;
    redir_ld = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (branch_taken) begin
          pc_ld = 1'b1;
          pc_d  = branch_target;
        end
      end
      REQ: begin
        if (mem_ack) begin
          // The outstanding read completes; a redirect always clears squash.
          squash_d = 1'b0;
          if (branch_taken) begin
            pc_ld = 1'b1;
            pc_d  = branch_target;
          end else if (squash_q) begin
            pc_ld = 1'b1;
            pc_d  = redir_q;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else if (branch_taken) begin
          // Read cannot be abandoned: remember the target, drop the data later.
          redir_ld = 1'b1;
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_ld   = 1'b1;
          pc_d    = branch_target;
          state_d = REQ;
        end else if (instr_ready) begin
          pc_ld   = 1'b1;
          pc_d    = pc_q + ADDR_W'(PC_STEP);
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and squash flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
    end
  end

  // Instruction output registers, loaded only by a good-path ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
    end else if (capture) begin
      instr_q    <= mem_rdata;
      instr_pc_q <= pc_q;
    end
  end

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level model of the architectural fetch stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clk;
  logic         reset;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         instr_ready;
  logic         branch_taken;
  logic [7:0]   branch_target;

  logic         mem_req, instr_valid;
  logic [7:0]   mem_addr, instr_pc;
  logic [31:0]  instr;
  fetch_state_e dbg_state;

  logic         w_mem_req, w_instr_valid;
  logic [7:0]   w_mem_addr, w_instr_pc;
  logic [31:0]  w_instr;
  fetch_state_e w_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dbg_state(dbg_state)
  );

  fetch_unit #(.RESET_PC(8'hF8)) u_wrap (
    .clk(clk), .reset(reset), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(w_instr_valid),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dbg_state(w_dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents are a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic reset_dut();
    reset = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00; mem_rdata = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", mem_req); end
    n_vec++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr got %h want 00", mem_addr); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr); end
    n_vec++; if (instr_pc !== 8'h00) begin n_err++; $display("FAIL rst_pc got %h want 00", instr_pc); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state got %0d want IDLE", dbg_state); end
    n_vec++; if (w_mem_addr !== 8'hF8) begin n_err++; $display("FAIL rst_waddr got %h want f8", w_mem_addr); end
    reset = 1'b1;
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_req got %b want 0", mem_req); end
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL first_req got %b want 1", mem_req); end
  endtask

  // ack and ready tied high from the first REQ cycle.
  task automatic test_stream();
    logic [7:0] e;
    mem_ack = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = 8'(4 * (i / 2));
      n_vec++; if (mem_req !== (i % 2 == 0)) begin n_err++; $display("FAIL stream_req[%0d] got %b", i, mem_req); end
      n_vec++; if (instr_valid !== (i % 2 == 1)) begin n_err++; $display("FAIL stream_valid[%0d] got %b", i, instr_valid); end
      if (i % 2 == 0) begin
        n_vec++; if (mem_addr !== e) begin n_err++; $display("FAIL stream_addr[%0d] got %h want %h", i, mem_addr, e); end
        n_vec++; if (w_mem_addr !== 8'(8'hF8 + e)) begin n_err++; $display("FAIL wrap_addr[%0d] got %h want %h", i, w_mem_addr, 8'(8'hF8 + e)); end
      end else begin
        n_vec++; if (instr_pc !== e) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, instr_pc, e); end
        n_vec++; if (instr !== mem_word(e)) begin n_err++; $display("FAIL stream_instr[%0d] got %h want %h", i, instr, mem_word(e)); end
        n_vec++; if (w_instr_pc !== 8'(8'hF8 + e)) begin n_err++; $display("FAIL wrap_pc[%0d] got %h want %h", i, w_instr_pc, 8'(8'hF8 + e)); end
      end
      mem_rdata = mem_word(mem_addr);
      @(negedge clk);
    end
    mem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_wait();
    int budget;
    reset_dut();
    mem_ack = 1'b1; instr_ready = 1'b1;
    budget = 0;
    while (!(mem_req === 1'b1 && mem_addr === 8'h08) && budget < 20) begin
      mem_rdata = mem_word(mem_addr);
      @(negedge clk);
      budget++;
    end
    n_vec++; if (budget >= 20) begin n_err++; $display("FAIL wait_reach got addr %h want 08", mem_addr); end
    mem_ack = 1'b0; instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL wait_req[%0d] got %b want 1", k, mem_req); end
      n_vec++; if (mem_addr !== 8'h08) begin n_err++; $display("FAIL wait_addr[%0d] got %h want 08", k, mem_addr); end
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid[%0d] got %b want 0", k, instr_valid); end
      mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0008;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL wait_done_valid got %b want 1", instr_valid); end
    n_vec++; if (instr !== 32'hA5A5_0008) begin n_err++; $display("FAIL wait_instr got %h want a5a50008", instr); end
    n_vec++; if (instr_pc !== 8'h08) begin n_err++; $display("FAIL wait_pc got %h want 08", instr_pc); end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", k, instr_valid); end
      n_vec++; if (instr !== 32'hA5A5_0008) begin n_err++; $display("FAIL stall_instr[%0d] got %h", k, instr); end
      n_vec++; if (instr_pc !== 8'h08) begin n_err++; $display("FAIL stall_pc[%0d] got %h want 08", k, instr_pc); end
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got %b want 0", k, mem_req); end
      @(negedge clk);
    end
    mem_ack = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_rel_valid got %b want 0", instr_valid); end
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stall_rel_req got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 8'h0C) begin n_err++; $display("FAIL stall_rel_addr got %h want 0c", mem_addr); end
  endtask

  // Starts in REQ at 0C with no ack pending.
  task automatic test_branch_req();
    branch_taken = 1'b1; branch_target = 8'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    n_vec++; if (mem_addr !== 8'h0C || mem_req !== 1'b1) begin n_err++; $display("FAIL br_keep1 got req %b addr %h want 1 0c", mem_req, mem_addr); end
    mem_rdata = $urandom;
    @(negedge clk);
    n_vec++; if (mem_addr !== 8'h0C || mem_req !== 1'b1) begin n_err++; $display("FAIL br_keep2 got req %b addr %h want 1 0c", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = mem_word(8'h0C);
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL br_squash_valid got %b want 0", instr_valid); end
    n_vec++; if (mem_addr !== 8'h40 || mem_req !== 1'b1) begin n_err++; $display("FAIL br_target got req %b addr %h want 1 40", mem_req, mem_addr); end
    branch_taken = 1'b1; branch_target = 8'h60;
    @(negedge clk);
    branch_taken = 1'b0;
    n_vec++; if (mem_addr !== 8'h40) begin n_err++; $display("FAIL br2_keep1 got %h want 40", mem_addr); end
    branch_taken = 1'b1; branch_target = 8'h80;
    @(negedge clk);
    branch_taken = 1'b0;
    n_vec++; if (mem_addr !== 8'h40 || mem_req !== 1'b1) begin n_err++; $display("FAIL br2_keep2 got req %b addr %h want 1 40", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = mem_word(8'h40);
    @(negedge clk);
    n_vec++; if (mem_addr !== 8'h80 || instr_valid !== 1'b0) begin n_err++; $display("FAIL br2_target got addr %h valid %b want 80 0", mem_addr, instr_valid); end
    mem_rdata = mem_word(8'h80);
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 8'h80) begin n_err++; $display("FAIL br2_fetch got valid %b pc %h want 1 80", instr_valid, instr_pc); end
    n_vec++; if (instr !== mem_word(8'h80)) begin n_err++; $display("FAIL br2_instr got %h want %h", instr, mem_word(8'h80)); end
  endtask

  // Starts in HOLD with the instruction at 80.
  task automatic test_branch_hold();
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h20;
    @(negedge clk);
    instr_ready = 1'b0; branch_taken = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL bh_valid got %b want 0", instr_valid); end
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 8'h20) begin n_err++; $display("FAIL bh_addr got req %b addr %h want 1 20", mem_req, mem_addr); end
  endtask

  // Starts in REQ at 20; reset lands between edges with an ack pending.
  task automatic test_reset_mid();
    mem_ack = 1'b1; mem_rdata = mem_word(8'h20);
    #2 reset = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctl got req %b valid %b want 0 0", mem_req, instr_valid); end
    n_vec++; if (mem_addr !== 8'h00 || instr_pc !== 8'h00) begin n_err++; $display("FAIL mid_rst_addr got addr %h pc %h want 00 00", mem_addr, instr_pc); end
    n_vec++; if (instr !== 32'h0 || dbg_state !== IDLE) begin n_err++; $display("FAIL mid_rst_instr got %h state %0d want 0 IDLE", instr, dbg_state); end
    @(negedge clk);
    n_vec++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold got req %b valid %b want 0 0", mem_req, instr_valid); end
    mem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin n_err++; $display("FAIL mid_rst_restart got req %b addr %h want 1 00", mem_req, mem_addr); end
  endtask

  // Random traffic. The model tracks only the architectural next-fetch PC:
  // a branch redirects it, an accepted instruction advances it by 4, and
  // every accepted instruction must carry that PC and its memory word.
  task automatic test_random();
    logic [7:0] exp_pc;
    logic       expect_drop, prev_req, prev_ack;
    logic [7:0] prev_addr;
    logic [31:0] exp_q[$];
    int         accepted;
    reset_dut();
    exp_pc = 8'h00; expect_drop = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
    prev_addr = 8'h00; accepted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (expect_drop) begin
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rnd_drop cyc %0d got valid %b want 0", cyc, instr_valid); end
      end
      if (prev_req && !prev_ack) begin
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin n_err++; $display("FAIL rnd_hold cyc %0d got req %b addr %h want 1 %h", cyc, mem_req, mem_addr, prev_addr); end
      end
      n_vec++; if (mem_req === 1'b1 && instr_valid === 1'b1) begin n_err++; $display("FAIL rnd_excl cyc %0d got req and valid both 1", cyc); end
      mem_ack = 1'($urandom_range(0, 1));
      instr_ready = ($urandom_range(0, 9) < 6);
      branch_taken = ($urandom_range(0, 15) == 0);
      branch_target = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 63) * 4);
      mem_rdata = (mem_ack && mem_req) ? mem_word(mem_addr) : $urandom;
      if (branch_taken) begin
        exp_pc = branch_target;
        expect_drop = 1'b1;
      end else begin
        expect_drop = 1'b0;
        if (instr_valid === 1'b1 && instr_ready) begin
          exp_q.push_back({exp_pc, mem_word(exp_pc)[23:0]});
          n_vec++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h want %h", cyc, instr_pc, exp_pc); end
          n_vec++; if (instr !== mem_word(exp_pc)) begin n_err++; $display("FAIL rnd_instr cyc %0d got %h want %h", cyc, instr, mem_word(exp_pc)); end
          exp_pc = exp_pc + 8'd4;
          accepted++;
        end
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      @(negedge clk);
    end
    mem_ack = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    n_vec++; if (exp_q.size() < 50) begin n_err++; $display("FAIL rnd_progress got %0d accepted want >= 50", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00; mem_rdata = '0;
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_branch_req();
    test_branch_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
